id_stage_p: RTL and testbench
=============================

ID_STAGE_P -- requirements
Module: id_stage_p

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, 32, operand/immediate width (legal range 16..64).
REQ-002 The block SHALL have parameter ZEXT_MASK, 16'h0000, bit i set means opcode i zero-extends imm16, else sign-extends.
REQ-003 The block SHALL have parameter RS2_USE_MASK, 16'hFFFF, bit i set means opcode i reads rs2; rs1 is always read.
REQ-004 The block SHALL have parameter REG0_ZERO, 1, register 0 reads as zero, never bypassed, never a hazard source.
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have clk, in, 1, sole clock, rising edge.
REQ-006 The block SHALL have rst, in, 1, reset, asynchronous, active-high.
REQ-007 The block SHALL have instr_in in 32, pc_in in 32, in_valid in 1, in_ready out 1; fields are opcode[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm16[15:0].
REQ-008 The block SHALL have raddr1 out 4, raddr2 out 4, rdata1 in DATA_W, rdata2 in DATA_W: combinational register-file read.
REQ-009 The block SHALL have wb_we in 1, wb_addr in 4, wb_data in DATA_W: same-cycle writeback for bypass.
REQ-010 The block SHALL have ex_load_valid in 1, ex_load_rd in 4: load in EX whose result is not yet available.
REQ-011 The block SHALL have flush in 1: squash the held output and the current input.
REQ-012 The block SHALL have out_valid out 1, out_ready in 1, rd out 4, op out 4, imm out DATA_W, rs1_val out DATA_W, rs2_val out DATA_W, pc_out out 32.
REQ-013 The block SHALL have stall_cnt out 16: count of hazard-stall cycles.

Function
REQ-014 raddr1/raddr2 SHALL equal instr_in[23:20]/[19:16] combinationally, regardless of in_valid.
REQ-015 Operand value SHALL be wb_data when wb_we and wb_addr==raddr (and not reg 0 under REG0_ZERO), else 0 for reg 0 under REG0_ZERO, else rdata.
REQ-016 imm SHALL be imm16 zero- or sign-extended to DATA_W per ZEXT_MASK[opcode].
REQ-017 hazard SHALL be in_valid && ex_load_valid && (ex_load_rd==rs1 || (RS2_USE_MASK[opcode] && ex_load_rd==rs2)), excluding ex_load_rd==0 under REG0_ZERO.
REQ-018 in_ready SHALL be flush || ((!out_valid || out_ready) && !hazard).
REQ-019 Accept = in_valid && in_ready && !flush; on accept, the output register SHALL capture decoded fields, operands, imm, pc and set out_valid=1 at the next edge (latency 1).
REQ-020 When out_valid && out_ready && no accept, out_valid SHALL clear at the next edge; accept on the same edge SHALL keep out_valid=1 (full throughput, one instr/cycle).
REQ-021 While out_valid && !out_ready, all output fields SHALL hold stable.
REQ-022 flush SHALL clear out_valid at the next edge and discard the input; flush has priority over accept, hazard and out_ready.
REQ-023 stall_cnt SHALL increment on each cycle with hazard && !flush, saturating at 16'hFFFF.
REQ-024 Hazard and a blocked output simultaneously SHALL count as one stall cycle; output-blocked-only cycles SHALL NOT count.

Reset
REQ-025 While rst=1, out_valid SHALL be 0, and rd, op, imm, rs1_val, rs2_val, pc_out and stall_cnt SHALL be 0, asynchronously.
REQ-026 rst asserted mid-transfer SHALL drop the held instruction; first accept is possible on the first edge after deassertion.

Structure
REQ-027 cpu_defs_pkg SHALL hold opcode_t (4 bit), reg_addr_t (4 bit), and field bit-position constants; the block SHALL import them.
REQ-028 Hazard detection SHALL be a combinational sub-module id_hazard_unit; all state SHALL reside in id_stage_p.

Verification
REQ-029 rst, then instr 32'h1123_FFFE, pc 0x40, rdata1=5, rdata2=7, out_ready=1 -> next cycle out_valid=1, rd=1, op=1, rs1_val=5, rs2_val=7, imm=32'hFFFF_FFFE, pc_out=0x40.
REQ-030 ZEXT_MASK=16'h0002, same instr -> imm=32'h0000_FFFE.
REQ-031 wb_we=1, wb_addr=2, wb_data=0xAA, rdata1=5, rs1=2 -> rs1_val=0xAA; with wb_addr=0, rs1=0 -> rs1_val=0.
REQ-032 ex_load_valid=1, ex_load_rd=3, rs2=3, opcode bit set in RS2_USE_MASK, 3 cycles -> in_ready=0 for 3 cycles, stall_cnt=3, no out_valid; cleared -> accept next edge.
REQ-033 out_ready=0 with out_valid=1, new in_valid -> in_ready=0, outputs stable; out_ready=1 -> back-to-back instrs transfer one per cycle.
REQ-034 flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input dropped; rst pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Shared CPU definitions: opcode/register-address types and
//               instruction field bit positions, plus field extractors.
//               Instruction layout:
//                 opcode[31:28] rd[27:24] rs1[23:20] rs2[19:16] imm16[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [3:0] reg_addr_t;

  localparam int C_INSTR_W = 32;
  localparam int C_FIELD_W = 4;
  localparam int C_OPC_LSB = 28;
  localparam int C_RD_LSB  = 24;
  localparam int C_RS1_LSB = 20;
  localparam int C_RS2_LSB = 16;
  localparam int C_IMM_LSB = 0;
  localparam int C_IMM_W   = 16;

  function automatic opcode_t f_opcode(input logic [C_INSTR_W-1:0] instr);
    return instr[C_OPC_LSB +: C_FIELD_W];
  endfunction

  function automatic reg_addr_t f_rd(input logic [C_INSTR_W-1:0] instr);
    return instr[C_RD_LSB +: C_FIELD_W];
  endfunction

  function automatic reg_addr_t f_rs1(input logic [C_INSTR_W-1:0] instr);
    return instr[C_RS1_LSB +: C_FIELD_W];
  endfunction

  function automatic reg_addr_t f_rs2(input logic [C_INSTR_W-1:0] instr);
    return instr[C_RS2_LSB +: C_FIELD_W];
  endfunction

  function automatic logic [C_IMM_W-1:0] f_imm16(input logic [C_INSTR_W-1:0] instr);
    return instr[C_IMM_LSB +: C_IMM_W];
  endfunction

endpackage : cpu_defs_pkg
`default_nettype wire

// File: rtl/id_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_unit
// Description : Combinational load-use hazard detector for the decode stage.
//               Flags a hazard when a valid instruction reads a register that
//               an in-flight load in EX has not yet produced.
// Ports       : i_in_valid       - decode input holds a valid instruction
//               i_ex_load_valid  - a load occupies EX
//               i_ex_load_rd     - destination of that load
//               i_rs1, i_rs2     - source registers of the decode instruction
//               i_rs2_used       - instruction actually reads rs2
//               o_hazard         - stall request
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_unit
  import cpu_defs_pkg::*;
#(
  parameter bit REG0_ZERO = 1'b1
) (
  input  logic      i_in_valid,
  input  logic      i_ex_load_valid,
  input  reg_addr_t i_ex_load_rd,
  input  reg_addr_t i_rs1,
  input  reg_addr_t i_rs2,
  input  logic      i_rs2_used,
  output logic      o_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_load_to_r0;

  assign w_rs1_match  = (i_ex_load_rd == i_rs1);
  assign w_rs2_match  = i_rs2_used && (i_ex_load_rd == i_rs2);
  // A load targeting r0 produces nothing observable when r0 is hardwired.
  assign w_load_to_r0 = REG0_ZERO && (i_ex_load_rd == 4'd0);

  assign o_hazard = i_in_valid && i_ex_load_valid && !w_load_to_r0 &&
                    (w_rs1_match || w_rs2_match);

endmodule : id_hazard_unit
`default_nettype wire

// File: rtl/id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_p
// Description : Pipelined instruction-decode stage. Reads the register file
//               combinationally, bypasses same-cycle writeback, extends the
//               immediate, stalls on load-use hazards and holds the decoded
//               instruction in a valid/ready output register.
// Ports       : clk, rst                   - clock, async active-high reset
//               instr_in, pc_in, in_valid,
//               in_ready                   - upstream handshake
//               raddr1/2, rdata1/2         - register-file read port
//               wb_we, wb_addr, wb_data    - writeback bypass
//               ex_load_valid, ex_load_rd  - load in EX (hazard source)
//               flush                      - squash held and incoming instr
//               out_valid, out_ready, rd, op, imm, rs1_val, rs2_val,
//               pc_out                     - downstream handshake + payload
//               stall_cnt                  - saturating hazard-stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_p
  import cpu_defs_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter logic [15:0] ZEXT_MASK    = 16'h0000,
  parameter logic [15:0] RS2_USE_MASK = 16'hFFFF,
  parameter bit          REG0_ZERO    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        raddr1,
  output logic [3:0]        raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              wb_we,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_load_valid,
  input  logic [3:0]        ex_load_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        rd,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  output logic [31:0]       pc_out,
  output logic [15:0]       stall_cnt
);

  // --------------------------------------------------------------------------
  // Field decode
  // --------------------------------------------------------------------------
  opcode_t          opc;
  reg_addr_t        rs1_a;
  reg_addr_t        rs2_a;
  logic [15:0]      imm16;

  assign opc    = f_opcode(instr_in);
  assign rs1_a  = f_rs1(instr_in);
  assign rs2_a  = f_rs2(instr_in);
  assign imm16  = f_imm16(instr_in);
  assign raddr1 = rs1_a;
  assign raddr2 = rs2_a;

  // --------------------------------------------------------------------------
  // Operand selection: hardwired r0 wins over bypass, bypass over regfile.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;

  always_comb begin
    opnd1 = rdata1;
    if (REG0_ZERO && (rs1_a == 4'd0)) begin
      opnd1 = '0;
    end else if (wb_we && (wb_addr == rs1_a)) begin
      opnd1 = wb_data;
    end
  end

  always_comb begin
    opnd2 = rdata2;
    if (REG0_ZERO && (rs2_a == 4'd0)) begin
      opnd2 = '0;
    end else if (wb_we && (wb_addr == rs2_a)) begin
      opnd2 = wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Immediate extension; loop form keeps DATA_W == 16 legal.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] imm_ext;

  always_comb begin
    imm_ext       = '0;
    imm_ext[15:0] = imm16;
    if (!ZEXT_MASK[opc]) begin
      for (int i = 16; i < DATA_W; i++) begin
        imm_ext[i] = imm16[15];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hazard and handshake
  // --------------------------------------------------------------------------
  logic hazard;
  logic accept;

  id_hazard_unit #(
    .REG0_ZERO (REG0_ZERO)
  ) u_hazard (
    .i_in_valid      (in_valid),
    .i_ex_load_valid (ex_load_valid),
    .i_ex_load_rd    (ex_load_rd),
    .i_rs1           (rs1_a),
    .i_rs2           (rs2_a),
    .i_rs2_used      (RS2_USE_MASK[opc]),
    .o_hazard        (hazard)
  );

  logic out_valid_q, out_valid_d;

  // During flush the input is accepted only to be thrown away, so upstream
  // never blocks on a squashed instruction.
  assign in_ready = flush || ((!out_valid_q || out_ready) && !hazard);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [3:0]        rd_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] rs1_val_q;
  logic [DATA_W-1:0] rs2_val_q;
  logic [31:0]       pc_q;
  logic [15:0]       stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        rd_q      <= f_rd(instr_in);
        op_q      <= opc;
        imm_q     <= imm_ext;
        rs1_val_q <= opnd1;
        rs2_val_q <= opnd2;
        pc_q      <= pc_in;
      end
    end
  end

  // Only hazard cycles count; a cycle blocked purely by out_ready does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign op        = op_q;
  assign imm       = imm_q;
  assign rs1_val   = rs1_val_q;
  assign rs2_val   = rs2_val_q;
  assign pc_out    = pc_q;
  assign stall_cnt = stall_cnt_q;

endmodule : id_stage_p
`default_nettype wire

// File: tb/tb_id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_p
// Description : Self-checking bench for id_stage_p. Expected decode results
//               are queued when an instruction is handed over and compared
//               when the stage presents them downstream. A second instance
//               with different extension/rs2-use masks covers mask behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_p;

  localparam int DATA_W = 32;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, pc_in;
  logic        in_valid, in_ready;
  logic [3:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_load_valid;
  logic [3:0]  ex_load_rd;
  logic        flush;
  logic        out_valid, out_ready;
  logic [3:0]  rd, op;
  logic [31:0] imm, rs1_val, rs2_val, pc_out;
  logic [15:0] stall_cnt;

  // second instance outputs
  logic        z_in_ready, z_out_valid;
  logic [3:0]  z_raddr1, z_raddr2, z_rd, z_op;
  logic [31:0] z_imm, z_rs1_val, z_rs2_val, z_pc_out;
  logic [15:0] z_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_stage_p #(
    .DATA_W(DATA_W), .ZEXT_MASK(16'h0000), .RS2_USE_MASK(16'hFFFF), .REG0_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
    .in_valid(in_valid), .in_ready(in_ready), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
    .op(op), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val), .pc_out(pc_out),
    .stall_cnt(stall_cnt)
  );

  id_stage_p #(
    .DATA_W(DATA_W), .ZEXT_MASK(16'h0002), .RS2_USE_MASK(16'hFFFE), .REG0_ZERO(1'b1)
  ) dut_z (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
    .in_valid(in_valid), .in_ready(z_in_ready), .raddr1(z_raddr1), .raddr2(z_raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .flush(flush), .out_valid(z_out_valid), .out_ready(out_ready), .rd(z_rd),
    .op(z_op), .imm(z_imm), .rs1_val(z_rs1_val), .rs2_val(z_rs2_val), .pc_out(z_pc_out),
    .stall_cnt(z_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode for the default-parameter instance.
  function automatic logic [31:0] ref_opnd(input logic [3:0] a, input logic [31:0] rdv);
    if (a == 4'd0) return 32'd0;
    if (wb_we && (wb_addr == a)) return wb_data;
    return rdv;
  endfunction

  function automatic exp_t ref_decode();
    exp_t e;
    e.op  = instr_in[31:28];
    e.rd  = instr_in[27:24];
    e.imm = {{16{instr_in[15]}}, instr_in[15:0]};
    e.r1  = ref_opnd(instr_in[23:20], rdata1);
    e.r2  = ref_opnd(instr_in[19:16], rdata2);
    e.pc  = pc_in;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand over the instruction currently on the inputs; it must be accepted.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    instr_in = instr;
    pc_in    = pc;
    in_valid = 1'b1;
    #1;
    check("accept_ready", in_ready, 1);
    e = ref_decode();
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  // Scoreboard consumer: a transfer happens at the edge following this sample.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_rd",  rd,      e.rd);
        check("sb_op",  op,      e.op);
        check("sb_imm", imm,     e.imm);
        check("sb_rs1", rs1_val, e.r1);
        check("sb_rs2", rs2_val, e.r2);
        check("sb_pc",  pc_out,  e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_in = '0; pc_in = '0; in_valid = 0;
    rdata1 = '0; rdata2 = '0; wb_we = 0; wb_addr = '0; wb_data = '0;
    ex_load_valid = 0; ex_load_rd = '0; flush = 0; out_ready = 1;
    tick();
    tick();
    // reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_rd",        rd,        0);
    check("rst_imm",       imm,       0);
    check("rst_pc",        pc_out,    0);
    check("rst_stall",     stall_cnt, 0);
    rst = 1'b0;
    tick();

    // basic decode, sign vs zero extension
    rdata1 = 32'd5; rdata2 = 32'd7;
    instr_in = 32'h1123_FFFE;
    #1;
    check("raddr1", raddr1, 4'h2);
    check("raddr2", raddr2, 4'h3);
    send(32'h1123_FFFE, 32'h40);
    in_valid = 0;
    check("basic_valid", out_valid, 1);
    check("basic_rd",    rd,        4'h1);
    check("basic_op",    op,        4'h1);
    check("basic_rs1",   rs1_val,   32'd5);
    check("basic_rs2",   rs2_val,   32'd7);
    check("basic_imm",   imm,       32'hFFFF_FFFE);
    check("basic_pc",    pc_out,    32'h40);
    check("zext_imm",    z_imm,     32'h0000_FFFE);
    tick();
    check("drain_valid", out_valid, 0);

    // bypass and r0, back to back
    wb_we = 1; wb_addr = 4'd2; wb_data = 32'hAA;
    send(32'h2425_0010, 32'h44);
    check("byp_rs1", rs1_val, 32'hAA);
    wb_addr = 4'd0; wb_data = 32'hBB;
    send(32'h3506_8000, 32'h48);
    check("r0_rs1", rs1_val, 32'd0);
    wb_we = 0; in_valid = 0;
    tick();

    // load-use hazard for three cycles
    ex_load_valid = 1; ex_load_rd = 4'd3;
    instr_in = 32'h4513_0001; pc_in = 32'h4C; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("haz_ready", in_ready, 0);
      check("haz_valid", out_valid, 0);
      tick();
    end
    check("haz_stall_cnt", stall_cnt, 16'd3);
    ex_load_valid = 0;
    send(32'h4513_0001, 32'h4C);
    check("haz_release_valid", out_valid, 1);

    // load to r0 is never a hazard
    ex_load_valid = 1; ex_load_rd = 4'd0;
    send(32'h6700_0002, 32'h50);

    // opcode 0 does not read rs2 in the masked instance
    ex_load_rd = 4'd3;
    instr_in = 32'h0113_0000;
    #1;
    check("rs2use_dflt_ready", in_ready, 0);
    check("rs2use_mask_ready", z_in_ready, 1);
    in_valid = 0; ex_load_valid = 0;
    tick();

    // backpressure: hold A, then A and B move on consecutive edges
    send(32'h7812_1234, 32'h60);
    out_ready = 0;
    instr_in = 32'h8934_0042; pc_in = 32'h64; in_valid = 1;
    #1;
    check("bp_ready", in_ready, 0);
    tick();
    tick();
    check("bp_hold_rd", rd, 4'h8);
    check("bp_hold_pc", pc_out, 32'h60);
    check("bp_stall_cnt", stall_cnt, 16'd3);
    out_ready = 1;
    send(32'h8934_0042, 32'h64);
    check("bp_b_pc", pc_out, 32'h64);

    // flush squashes held B and incoming C; hazard during flush not counted
    out_ready = 0;
    instr_in = 32'h9A56_0000; pc_in = 32'h68; in_valid = 1;
    ex_load_valid = 1; ex_load_rd = 4'd5;
    flush = 1;
    #1;
    check("flush_ready", in_ready, 1);
    tick();
    flush = 0; in_valid = 0; ex_load_valid = 0;
    sb_q.delete();
    check("flush_valid", out_valid, 0);
    check("flush_stall_cnt", stall_cnt, 16'd3);
    out_ready = 1;
    tick();
    check("flush_no_c", out_valid, 0);

    // asynchronous reset mid-transfer
    out_ready = 0;
    send(32'hAB12_0003, 32'h70);
    in_valid = 0;
    rst = 1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_rd",    rd,        0);
    check("arst_rs1",   rs1_val,   0);
    check("arst_pc",    pc_out,    0);
    check("arst_stall", stall_cnt, 0);
    sb_q.delete();
    tick();
    rst = 0;
    out_ready = 1;
    send(32'hC123_0004, 32'h80);
    check("post_rst_valid", out_valid, 1);
    in_valid = 0;
    tick();
    tick();
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_id_stage_p
`default_nettype wire
